// File: rtl/simple_bus_dma_master_pkg.sv
// ============================================================
// simple_bus_dma_master_pkg: shared encodings for the SimpleBus DMA
// Rev 1.0
// ============================================================
`default_nettype none

package simple_bus_dma_master_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_READ  = S_READ,
    ST_WRITE = S_WRITE,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } state_t;

  localparam logic [3:0]  MASK_ALL   = 4'hF;
  localparam logic [3:0]  MASK_NONE  = 4'h0;
  localparam int          WORD_SHIFT = 2;
  localparam logic [31:0] ADDR_ALIGN = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_offset(input logic [31:0] words);
    return words << WORD_SHIFT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/simple_bus_dma_master_if.sv
// ============================================================
// simple_bus_dma_master_if: SimpleBus cmd/rsp channel bundle
// Rev 1.0
// ============================================================
`default_nettype none

interface simple_bus_dma_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_payload_write;
  logic [31:0] cmd_payload_address;
  logic [31:0] cmd_payload_data;
  logic [3:0]  cmd_payload_mask;
  logic        rsp_valid;
  logic [31:0] rsp_payload_data;

  modport master (
    output cmd_valid, cmd_payload_write, cmd_payload_address, cmd_payload_data, cmd_payload_mask,
    input  cmd_ready, rsp_valid, rsp_payload_data
  );

  modport slave (
    input  cmd_valid, cmd_payload_write, cmd_payload_address, cmd_payload_data, cmd_payload_mask,
    output cmd_ready, rsp_valid, rsp_payload_data
  );

endinterface

`default_nettype wire

// File: rtl/simple_bus_dma_buffer.sv
// ============================================================
// simple_bus_dma_buffer: BURST x 32 burst staging register file
// Rev 1.0
// ============================================================
`default_nettype none

module simple_bus_dma_buffer #(
  parameter int BURST = 4,
  parameter int IDX_W = (BURST > 1) ? $clog2(BURST) : 1
) (
  input  wire logic             clk,
  input  wire logic             i_wr_en,
  input  wire logic [IDX_W-1:0] i_wr_idx,
  input  wire logic [31:0]      i_wr_data,
  input  wire logic [IDX_W-1:0] i_rd_idx,
  output logic      [31:0]      o_rd_data
);

  logic [31:0] r_mem [BURST];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

`default_nettype wire

// File: rtl/simple_bus_dma_master.sv
// ============================================================
// simple_bus_dma_master: burst-wise memory-to-memory copy over SimpleBus
// Rev 1.0
// ============================================================
`default_nettype none

module simple_bus_dma_master
  import simple_bus_dma_master_pkg::*;
#(
  parameter int BURST   = 4,
  parameter int COUNT_W = 16
) (
  input  wire logic               io_mainClk,
  input  wire logic               resetCtrl_systemReset_n,
  input  wire logic               io_start,
  input  wire logic               io_abort,
  input  wire logic [31:0]        io_srcAddress,
  input  wire logic [31:0]        io_dstAddress,
  input  wire logic [COUNT_W-1:0] io_wordCount,
  output logic                    io_busy,
  output logic                    io_done,
  output logic                    io_aborted,
  simple_bus_dma_master_if.master io_bus
);

  localparam int CW = $clog2(BURST) + 1;
  localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;

  state_t             r_state;
  logic [31:0]        r_src;
  logic [31:0]        r_dst;
  logic [COUNT_W-1:0] r_remaining;
  logic [CW-1:0]      r_chunk;
  logic [CW-1:0]      r_issued;
  logic [CW-1:0]      r_received;
  logic [CW-1:0]      r_wr_cnt;
  logic               r_cmd_valid;
  logic               r_cmd_write;
  logic [31:0]        r_cmd_addr;
  logic [3:0]         r_cmd_mask;
  logic               r_abort;
  logic               r_busy;
  logic               r_done;
  logic               r_aborted;

  logic               w_fire;
  logic               w_abort_any;
  logic               w_abort_now;
  logic               w_rsp_take;
  logic [CW-1:0]      w_rcv_next;
  logic [CW-1:0]      w_iss_next;
  logic [CW-1:0]      w_wr_next;
  logic [31:0]        w_chunk_bytes;
  logic [COUNT_W-1:0] w_rem_next;
  logic [31:0]        w_rd_data;

  function automatic logic [CW-1:0] f_chunk(input logic [COUNT_W-1:0] rem);
    if (rem >= COUNT_W'(BURST)) return CW'(BURST);
    return rem[CW-1:0];
  endfunction

  assign w_fire        = r_cmd_valid & io_bus.cmd_ready;
  assign w_abort_any   = io_abort | r_abort;
  // A presented command must fire before abort takes effect.
  assign w_abort_now   = w_abort_any & (~r_cmd_valid | w_fire);
  assign w_rsp_take    = io_bus.rsp_valid & (r_received != r_issued) &
                         ((r_state == ST_READ) | (r_state == ST_DRAIN));
  assign w_rcv_next    = r_received + CW'(w_rsp_take);
  assign w_iss_next    = r_issued + CW'(1);
  assign w_wr_next     = r_wr_cnt + CW'(1);
  assign w_chunk_bytes = word_offset(32'(r_chunk));
  assign w_rem_next    = r_remaining - COUNT_W'(r_chunk);

  simple_bus_dma_buffer #(.BURST(BURST), .IDX_W(IW)) u_buffer (
    .clk       (io_mainClk),
    .i_wr_en   (w_rsp_take),
    .i_wr_idx  (r_received[IW-1:0]),
    .i_wr_data (io_bus.rsp_payload_data),
    .i_rd_idx  (r_wr_cnt[IW-1:0]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge io_mainClk) begin
    if (!resetCtrl_systemReset_n) begin
      r_state     <= ST_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_remaining <= '0;
      r_chunk     <= '0;
      r_issued    <= '0;
      r_received  <= '0;
      r_wr_cnt    <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_mask  <= MASK_NONE;
      r_abort     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_received <= w_rcv_next;
      case (r_state)
        ST_IDLE: begin
          if (io_start) begin
            r_src       <= io_srcAddress & ADDR_ALIGN;
            r_dst       <= io_dstAddress & ADDR_ALIGN;
            r_remaining <= io_wordCount;
            r_busy      <= 1'b1;
            r_abort     <= 1'b0;
            if (io_wordCount == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_READ;
              r_chunk     <= f_chunk(io_wordCount);
              r_issued    <= '0;
              r_received  <= '0;
              r_cmd_valid <= 1'b1;
              r_cmd_write <= 1'b0;
              r_cmd_mask  <= MASK_NONE;
              r_cmd_addr  <= io_srcAddress & ADDR_ALIGN;
            end
          end
        end
        ST_READ: begin
          if (w_fire) begin
            r_issued <= w_iss_next;
          end
          if (w_abort_now) begin
            r_cmd_valid <= 1'b0;
            r_abort     <= 1'b0;
            r_state     <= ST_DRAIN;
          end else begin
            if (w_abort_any) begin
              r_abort <= 1'b1;
            end
            if (w_fire) begin
              if (w_iss_next == r_chunk) begin
                r_cmd_valid <= 1'b0;
              end else begin
                r_cmd_addr <= r_src + word_offset(32'(w_iss_next));
              end
            end
            if (w_rcv_next == r_chunk) begin
              r_state     <= ST_WRITE;
              r_wr_cnt    <= '0;
              r_cmd_valid <= 1'b1;
              r_cmd_write <= 1'b1;
              r_cmd_mask  <= MASK_ALL;
              r_cmd_addr  <= r_dst;
            end
          end
        end
        ST_WRITE: begin
          if (w_abort_now) begin
            r_cmd_valid <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_mask  <= MASK_NONE;
            r_abort     <= 1'b0;
            r_state     <= ST_DRAIN;
          end else begin
            if (w_abort_any) begin
              r_abort <= 1'b1;
            end
            if (w_fire) begin
              r_wr_cnt <= w_wr_next;
              if (w_wr_next == r_chunk) begin
                r_remaining <= w_rem_next;
                r_src       <= r_src + w_chunk_bytes;
                r_dst       <= r_dst + w_chunk_bytes;
                r_cmd_write <= 1'b0;
                r_cmd_mask  <= MASK_NONE;
                if (w_rem_next == '0) begin
                  r_cmd_valid <= 1'b0;
                  r_state     <= ST_DONE;
                  r_done      <= 1'b1;
                end else begin
                  r_state    <= ST_READ;
                  r_chunk    <= f_chunk(w_rem_next);
                  r_issued   <= '0;
                  r_received <= '0;
                  r_cmd_addr <= r_src + w_chunk_bytes;
                end
              end else begin
                r_cmd_addr <= r_dst + word_offset(32'(w_wr_next));
              end
            end
          end
        end
        ST_DRAIN: begin
          if (r_received == r_issued) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_busy    = r_busy;
  assign io_done    = r_done;
  assign io_aborted = r_aborted;

  assign io_bus.cmd_valid           = r_cmd_valid;
  assign io_bus.cmd_payload_write   = r_cmd_write;
  assign io_bus.cmd_payload_address = r_cmd_addr;
  assign io_bus.cmd_payload_mask    = r_cmd_mask;
  // Buffer contents are undefined until filled, so data is gated to reads-as-zero.
  assign io_bus.cmd_payload_data    = r_cmd_write ? w_rd_data : 32'h0;

endmodule

`default_nettype wire
